ucounter_param: RTL and testbench
=================================

# ucounter_param

Parametrised successor to the team's fixed 16-bit up/down counter. It has programmable width, step size and count window (`min_val`..`max_val`), and supports wrap or stop at the window bounds. A RUN/HALT state machine latches a stop-mode boundary hit until software intervenes. The block is a drop-in counting primitive for timers, address generators and event counters in the datapath.

## Interface
- `WIDTH`, 16: counter width in bits.
- `STEP_WIDTH`, 4: width of the `step` input.
- `RESET_VAL`, 0: `dcount` value after reset.
- `clk` input 1: clock; all state updates on the rising edge.
- `_reset` input 1: reset, synchronous, active-high.
- `_set` input 1: synchronous load of `max_val`.
- `_load` input 1: synchronous load of `preld_val`.
- `preld_val` input WIDTH: preload value.
- `min_val` input WIDTH: lower window bound.
- `max_val` input WIDTH: upper window bound.
- `step` input STEP_WIDTH: count magnitude per enabled cycle; 0 means hold.
- `_updown` input 1: 1 counts up, 0 counts down.
- `_wrapstop` input 1: 1 selects wrap mode, 0 selects stop mode.
- `_carry_in` input 1: count enable.
- `_ovf_clr` input 1: clears the sticky flags (config-dependent).
- `dcount` output WIDTH: count value (registered).
- `overflow` output 1: a stop-mode up-crossing of `max_val` occurred (registered).
- `underflow` output 1: a stop-mode down-crossing of `min_val` occurred (registered).
- `wrap` output 1: one-cycle pulse on a wrap event (registered).
- `halted` output 1: FSM is in HALT (registered).
- `tc` output 1: combinational terminal count. High when `_updown`=1 and `dcount`==`max_val`, or when `_updown`=0 and `dcount`==`min_val`.
- `cfg_err` output 1: combinational; high when `min_val` > `max_val`.

## Operation
- Priority per edge: `_reset` > `_set` > `_load` > count.
- `_reset`:
  - `dcount`=RESET_VAL.
  - `overflow`, `underflow`, `wrap` and `halted` all = 0.
  - FSM goes to RUN.
- `_set`: `dcount`=`max_val`, FSM goes to RUN. `overflow` and `underflow` are unchanged; `wrap`=0.
- `_load`: `dcount`=`preld_val`, FSM goes to RUN. Flags behave as for `_set`.
- Counting happens only when all of the following hold:
  - FSM is in RUN,
  - `_carry_in`=1,
  - `cfg_err`=0,
  - `step`≠0.
- Otherwise `dcount` holds.
- Arithmetic is done in WIDTH+1 bits, with `step` zero-extended.
  - Up: sum = `dcount`+`step`. A crossing is sum > `max_val`.
  - Down: diff = `dcount`−`step`. A crossing is `dcount` < `min_val`+`step` (unsigned, WIDTH+1 bits).
- No crossing: `dcount` takes the new value.
- Crossing in wrap mode:
  - `dcount` goes to `min_val` (up) or `max_val` (down).
  - `wrap`=1 for exactly one cycle.
  - FSM stays in RUN.
- Crossing in stop mode:
  - `dcount` saturates to `max_val` (up) or `min_val` (down).
  - `overflow` (up) or `underflow` (down) is set.
  - FSM goes to HALT.
- HALT: `dcount` holds regardless of `_carry_in`, `_updown` and `_wrapstop`. It exits to RUN only via `_reset`, `_set` or `_load`.
- A `dcount` loaded outside the window uses the same crossing rules. Example: up from above `max_val` is a crossing on the next enabled cycle.
- Changing `min_val`/`max_val` mid-count takes effect on the next enabled edge. The crossing rules apply to the new bounds.

## Timing
- All outputs except `tc` and `cfg_err` are registered. The count, load, set and reset latency is 1 cycle.
- `overflow`, `underflow` and `wrap` update on the same edge as the `dcount` change that caused them.
- Same-cycle `_ovf_clr` and a new crossing: the set wins.
- `_reset` mid-count takes effect at the next edge with no residual flags.

## Configuration
- `UCOUNTER_STICKY_OVF_EN` defined:
  - `overflow`/`underflow` stay high until the edge on which `_ovf_clr`=1 or `_reset`=1.
  - `_load` and `_set` do not clear them.
- `UCOUNTER_STICKY_OVF_EN` undefined:
  - `overflow`/`underflow` are one-cycle pulses on the crossing edge.
  - `_ovf_clr` is ignored.
  - HALT behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=16 and RESET_VAL=0.
- Reset and count: `_reset`=1 for one cycle with min=0, max=0xFFFF, step=1, up, `_carry_in`=1. Expect `dcount`=0x0000 and all flags 0. After release, `dcount` reads 0x0001..0x0005 over 5 edges.
- Load and direction: `_load` 0x00FC, then 5 cycles up. Expect 0x0101. Then `_updown`=0 for 5 cycles. Expect back at 0x00FC; `tc` is low throughout.
- Wrap: min=0x0010, max=0x0100, step=3, load 0x00FE, wrap mode, up. Expect the next edge to give 0x0010 with `wrap`=1 for one cycle. Down from 0x0011 with step=3 gives 0x0100.
- Stop and halt: `_set` with max=0xFFFF, stop mode, up. Expect `dcount` held at 0xFFFF, `overflow`=1, `halted`=1. Toggling `_updown`=0 leaves 0xFFFF. `_load` 0x00FC gives `dcount`=0x00FC and `halted`=0.
- Sticky flag:
  - With the macro: `overflow` stays 1 for 5+ cycles, then clears on the `_ovf_clr` edge.
  - Without the macro: `overflow` is high for exactly one cycle.
- Simultaneous events and config error:
  - `_set`+`_load` same cycle gives `max_val`.
  - `_reset`+`_load` gives 0x0000.
  - min=0x0200, max=0x0100 gives `cfg_err`=1 and `dcount` holds.

Source files
------------

// File: rtl/ucounter_param.sv
// Parametrised up/down counter with min/max window, wrap or stop-and-halt bounds.
// Define UCOUNTER_STICKY_OVF_EN to make overflow/underflow sticky until _ovf_clr or _reset.
module ucounter_param #(
    parameter int unsigned           WIDTH      = 16,
    parameter int unsigned           STEP_WIDTH = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic                  _set,
    input  logic                  _load,
    input  logic [WIDTH-1:0]      preld_val,
    input  logic [WIDTH-1:0]      min_val,
    input  logic [WIDTH-1:0]      max_val,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  _updown,
    input  logic                  _wrapstop,
    input  logic                  _carry_in,
    input  logic                  _ovf_clr,
    output logic [WIDTH-1:0]      dcount,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  wrap,
    output logic                  halted,
    output logic                  tc,
    output logic                  cfg_err
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dcount_q, dcount_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH:0]   step_w;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   lim_dn_w;
    logic             cross_up;
    logic             cross_dn;
    logic             count_en;

    assign cfg_err = (min_val > max_val);
    assign tc      = _updown ? (dcount_q == max_val) : (dcount_q == min_val);

    // Crossing tests use one extra bit so up-sums and min+step never wrap.
    always_comb begin
        step_w   = (WIDTH+1)'(step);
        sum_w    = {1'b0, dcount_q} + step_w;
        lim_dn_w = {1'b0, min_val} + step_w;
        cross_up = (sum_w > {1'b0, max_val});
        cross_dn = ({1'b0, dcount_q} < lim_dn_w);
        count_en = (state_q == RUN) && _carry_in && !cfg_err && (step != '0);
    end

    always_comb begin
        dcount_d = dcount_q;
        state_d  = state_q;
        wrap_d   = 1'b0;
`ifdef UCOUNTER_STICKY_OVF_EN
        overflow_d  = overflow_q  & ~_ovf_clr;
        underflow_d = underflow_q & ~_ovf_clr;
`else
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
`endif
        if (_set) begin
            dcount_d = max_val;
            state_d  = RUN;
        end else if (_load) begin
            dcount_d = preld_val;
            state_d  = RUN;
        end else if (count_en) begin
            if (_updown) begin
                if (!cross_up) begin
                    dcount_d = sum_w[WIDTH-1:0];
                end else if (_wrapstop) begin
                    dcount_d = min_val;
                    wrap_d   = 1'b1;
                end else begin
                    dcount_d   = max_val;
                    overflow_d = 1'b1;
                    state_d    = HALT;
                end
            end else begin
                if (!cross_dn) begin
                    dcount_d = dcount_q - WIDTH'(step);
                end else if (_wrapstop) begin
                    dcount_d = max_val;
                    wrap_d   = 1'b1;
                end else begin
                    dcount_d    = min_val;
                    underflow_d = 1'b1;
                    state_d     = HALT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (_reset) begin
            dcount_q    <= RESET_VAL;
            state_q     <= RUN;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            dcount_q    <= dcount_d;
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            wrap_q      <= wrap_d;
        end
    end

    assign dcount    = dcount_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign wrap      = wrap_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_ucounter_param.sv
// Directed table-driven bench for ucounter_param (WIDTH=16, RESET_VAL=0).
module tb_ucounter_param;

`ifdef UCOUNTER_STICKY_OVF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        r_reset = 1'b0, r_set = 1'b0, r_load = 1'b0;
    logic [15:0] preld_val = '0, min_val = '0, max_val = 16'hFFFF;
    logic [3:0]  step = 4'd1;
    logic        r_updown = 1'b1, r_wrapstop = 1'b1, r_carry_in = 1'b0, r_ovf_clr = 1'b0;
    logic [15:0] dcount;
    logic        overflow, underflow, wrap, halted, tc, cfg_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ucounter_param #(.WIDTH(16), .STEP_WIDTH(4), .RESET_VAL(16'h0000)) dut (
        .clk(clk), ._reset(r_reset), ._set(r_set), ._load(r_load),
        .preld_val(preld_val), .min_val(min_val), .max_val(max_val), .step(step),
        ._updown(r_updown), ._wrapstop(r_wrapstop), ._carry_in(r_carry_in),
        ._ovf_clr(r_ovf_clr), .dcount(dcount), .overflow(overflow),
        .underflow(underflow), .wrap(wrap), .halted(halted), .tc(tc), .cfg_err(cfg_err)
    );

    typedef struct {
        logic        rst, set, ld;
        logic [15:0] p, mn, mx;
        logic [3:0]  st;
        logic        ud, ws, ci, clr;
        logic [15:0] e_dc;
        logic        e_ov, e_un, e_wr, e_hl, e_tc, e_ce;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic set, logic ld, logic [15:0] p,
                                logic [15:0] mn, logic [15:0] mx, logic [3:0] st,
                                logic ud, logic ws, logic ci, logic clr,
                                logic [15:0] dc, logic ov, logic un, logic wr,
                                logic hl, logic t, logic ce);
        vec_t v;
        v.rst = rst; v.set = set; v.ld = ld; v.p = p; v.mn = mn; v.mx = mx; v.st = st;
        v.ud = ud; v.ws = ws; v.ci = ci; v.clr = clr;
        v.e_dc = dc; v.e_ov = ov; v.e_un = un; v.e_wr = wr; v.e_hl = hl; v.e_tc = t; v.e_ce = ce;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        r_reset = v.rst; r_set = v.set; r_load = v.ld; preld_val = v.p;
        min_val = v.mn; max_val = v.mx; step = v.st; r_updown = v.ud;
        r_wrapstop = v.ws; r_carry_in = v.ci; r_ovf_clr = v.clr;
    endtask

    initial begin
        int n;
        int hi;
        // reset and count
        vecs.push_back(mk(1,0,0,16'h0,16'h0,16'hFFFF,1,1,1,1,0, 16'h0000,0,0,0,0,0,0));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0,0,0,16'h0,16'h0,16'hFFFF,1,1,1,1,0, 16'(i),0,0,0,0,0,0));
        // load and direction
        vecs.push_back(mk(0,0,1,16'h00FC,16'h0,16'hFFFF,1,1,1,1,0, 16'h00FC,0,0,0,0,0,0));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0,0,0,16'h0,16'h0,16'hFFFF,1,1,1,1,0, 16'(16'h00FC + i),0,0,0,0,0,0));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0,0,0,16'h0,16'h0,16'hFFFF,1,0,1,1,0, 16'(16'h0101 - i),0,0,0,0,0,0));
        // wrap
        vecs.push_back(mk(0,0,1,16'h00FE,16'h0010,16'h0100,3,1,1,1,0, 16'h00FE,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0010,16'h0100,3,1,1,1,0, 16'h0010,0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0010,16'h0100,3,1,1,1,0, 16'h0013,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,16'h0011,16'h0010,16'h0100,3,0,1,1,0, 16'h0011,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0010,16'h0100,3,0,1,1,0, 16'h0100,0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0010,16'h0100,3,0,1,1,0, 16'h00FD,0,0,0,0,0,0));
        // stop and halt
        vecs.push_back(mk(0,1,0,16'h0,16'h0,16'hFFFF,1,1,0,1,0, 16'hFFFF,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0,16'hFFFF,1,1,0,1,0, 16'hFFFF,1,0,0,1,1,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0,16'h0,16'h0,16'hFFFF,1,0,0,1,0, 16'hFFFF,STICKY,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0,16'hFFFF,1,0,0,1,1, 16'hFFFF,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,1,16'h00FC,16'h0,16'hFFFF,1,1,0,1,0, 16'h00FC,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0,16'hFFFF,1,1,0,1,0, 16'h00FD,0,0,0,0,0,0));
        // underflow stop, then _set keeps the sticky flag
        vecs.push_back(mk(0,0,1,16'h0002,16'h0,16'hFFFF,3,0,0,1,0, 16'h0002,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0,16'hFFFF,3,0,0,1,0, 16'h0000,0,1,0,1,1,0));
        vecs.push_back(mk(0,1,0,16'h0,16'h0,16'hFFFF,3,0,0,1,0, 16'hFFFF,0,STICKY,0,0,0,0));
        vecs.push_back(mk(1,0,0,16'h0,16'h0,16'hFFFF,3,0,0,1,0, 16'h0000,0,0,0,0,1,0));
        // simultaneous controls
        vecs.push_back(mk(0,1,1,16'h1234,16'h0,16'hFFFF,3,1,0,1,0, 16'hFFFF,0,0,0,0,1,0));
        vecs.push_back(mk(1,0,1,16'h1234,16'h0,16'hFFFF,3,1,0,1,0, 16'h0000,0,0,0,0,0,0));
        // config error, then loaded value above a newly lowered max
        vecs.push_back(mk(0,0,1,16'h0150,16'h0,16'hFFFF,1,1,1,1,0, 16'h0150,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0200,16'h0100,1,1,1,1,0, 16'h0150,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,16'h0,16'h0200,16'h0100,1,1,1,1,0, 16'h0150,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,16'h0,16'h0000,16'h0100,1,1,1,1,0, 16'h0000,0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0000,16'h0100,0,1,1,1,0, 16'h0000,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0000,16'h0100,1,1,1,0,0, 16'h0000,0,0,0,0,0,0));
        // exact hit on max is not a crossing; crossing beats same-cycle clear
        vecs.push_back(mk(0,0,1,16'h00FF,16'h0,16'h0100,1,1,0,1,0, 16'h00FF,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0,16'h0100,1,1,0,1,0, 16'h0100,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,16'h0,16'h0,16'h0100,1,1,0,1,1, 16'h0100,1,0,0,1,1,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check("dcount",    i, 32'(dcount),    32'(vecs[i].e_dc));
            check("overflow",  i, 32'(overflow),  32'(vecs[i].e_ov));
            check("underflow", i, 32'(underflow), 32'(vecs[i].e_un));
            check("wrap",      i, 32'(wrap),      32'(vecs[i].e_wr));
            check("halted",    i, 32'(halted),    32'(vecs[i].e_hl));
            check("tc",        i, 32'(tc),        32'(vecs[i].e_tc));
            check("cfg_err",   i, 32'(cfg_err),   32'(vecs[i].e_ce));
        end

        // Count from 0xFFF0 by 1 in stop mode: 15 edges to 0xFFFF, 16th halts.
        @(negedge clk);
        r_reset = 1; r_set = 0; r_load = 0; r_ovf_clr = 0; r_carry_in = 0;
        @(negedge clk);
        r_reset = 0; r_load = 1; preld_val = 16'hFFF0; min_val = 16'h0; max_val = 16'hFFFF;
        step = 1; r_updown = 1; r_wrapstop = 0; r_carry_in = 1;
        @(negedge clk);
        r_load = 0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (halted) break;
        end
        check("edges_to_halt", 100, 32'(n), 32'd16);
        check("halt_dcount",   100, 32'(dcount), 32'hFFFF);

        // Overflow width: crossing edge plus 8 held edges.
        hi = overflow ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (overflow) hi++;
        end
        check("ovf_cycles", 101, 32'(hi), STICKY ? 32'd9 : 32'd1);
        check("still_halted", 101, 32'(halted), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
